lsu_mem_master: RTL

//  Load/store initiator between the CPU memory stage and the 4 KiB byte-lane RAM (word address [11:2], 4 byte write enables).
//  - RAM read data is combinational from the address. Byte-lane writes commit on posedge clk.
//  - Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM beats.
//  - Splits misaligned accesses into two beats. Returns sign- or zero-extended load data over a valid/ready handshake.

---
 rtl/lsu_mem_master.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns byte-addressed CPU requests into one or two beats on a
// 1024 x 32 byte-lane RAM and returns extended load data with a one-cycle response pulse.
module lsu_mem_master #(
  parameter int MISALIGNED_SPLIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [9:0]  mem_address,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out,
  output logic [3:0]  mem_we
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Align the two beats so the requested bytes sit at [n*8-1:0], then extend.
  function automatic logic [31:0] load_extend(input logic [63:0] both, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    sh = both >> {off, 3'b000};
    case (size)
      2'b00:   load_extend = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_extend = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = sh[31:0];
    endcase
  endfunction

  state_e      state_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] resp_rdata_q;
  logic [9:0]  mem_address_q;
  logic [31:0] mem_in_q;

  logic        write_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [9:0]  waddr_q;
  logic [6:0]  mask_q;
  logic [55:0] wide_q;
  logic [31:0] lo_q;

  logic        accept;
  logic [2:0]  req_n;
  logic [3:0]  req_lanes;
  logic [3:0]  req_end;
  logic        req_cross;
  logic        req_fault;
  logic [6:0]  req_mask;
  logic [31:0] req_data_m;
  logic [55:0] req_wide;
  logic        need_beat1;

  assign accept     = req_valid && (state_q == S_IDLE);
  assign req_n      = size_bytes(req_size);
  assign req_lanes  = lane_mask(req_size);
  assign req_end    = {2'b00, req_addr[1:0]} + {1'b0, req_n};
  assign req_cross  = req_end > 4'd4;
  assign req_fault  = (|req_addr[31:12]) || (req_size == 2'b11) ||
                      (req_cross && ((MISALIGNED_SPLIT == 0) || (req_addr[11:2] == 10'h3FF)));
  assign req_mask   = {3'b000, req_lanes} << req_addr[1:0];
  // Bytes above the access size are cleared so they never reach the RAM bus.
  assign req_data_m = req_wdata & {{8{req_lanes[3]}}, {8{req_lanes[2]}},
                                   {8{req_lanes[1]}}, {8{req_lanes[0]}}};
  assign req_wide   = {24'd0, req_data_m} << {req_addr[1:0], 3'b000};
  assign need_beat1 = |mask_q[6:4];

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_fault  = resp_fault_q;
  assign mem_address = mem_address_q;
  assign mem_in      = mem_in_q;

  // Write enables come straight from state so an asynchronous reset kills them at once.
  always_comb begin
    mem_we = 4'b0000;
    if (write_q && (state_q == S_BEAT0)) mem_we = mask_q[3:0];
    if (write_q && (state_q == S_BEAT1)) mem_we = {1'b0, mask_q[6:4]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      resp_valid_q  <= 1'b0;
      resp_fault_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
      mem_address_q <= 10'd0;
      mem_in_q      <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (req_fault) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q       <= S_BEAT0;
              mem_address_q <= req_addr[11:2];
              mem_in_q      <= req_wide[31:0];
            end
          end
        end
        S_BEAT0: begin
          if (need_beat1) begin
            state_q       <= S_BEAT1;
            mem_address_q <= waddr_q + 10'd1;
            mem_in_q      <= {8'd0, wide_q[55:32]};
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= write_q ? 32'd0 : load_extend({32'd0, mem_out}, off_q, size_q, uns_q);
          end
        end
        S_BEAT1: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= write_q ? 32'd0 : load_extend({mem_out, lo_q}, off_q, size_q, uns_q);
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Request fields and the first read beat: pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      off_q   <= req_addr[1:0];
      waddr_q <= req_addr[11:2];
      mask_q  <= req_mask;
      wide_q  <= req_wide;
    end
    if (state_q == S_BEAT0) lo_q <= mem_out;
  end

endmodule
